fft_mem_rd_arbiter: RTL and testbench
=====================================

Name: fft_mem_rd_arbiter

Overview:
- Arbitrates the single read port of the post-FFT RX sample RAM between two requesters:
  - DMRS-index generator (channel-estimation path, requester 0).
  - PBCH-index generator (equalizer path, requester 1).
- Replaces the select-driven address mux / data demux with a granted, tag-tracked read pipeline.
- Returns each sample only to its issuing requester, with a valid strobe, and drains cleanly on disable.

Parameters:
- ADDR_WIDTH, 10, FFT RAM read-address width.
- RX_WORD_LENGTH, 12, width of each I/Q sample word.
- RD_LATENCY, 1, FFT RAM read latency in cycles, from rd_en/addr to data; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- arb_en  in  1  level; 1 = grants allowed, 0 = stop granting and drain.
- arb_idle  out  1  1 when in IDLE with no reads in flight.
- dmrs_req  in  1  DMRS read request; held with dmrs_addr stable until granted.
- dmrs_addr  in  ADDR_WIDTH  DMRS read address.
- dmrs_gnt  out  1  combinational grant; the read is accepted in this cycle.
- pbch_req  in  1  PBCH read request; same rules as dmrs_req.
- pbch_addr  in  ADDR_WIDTH  PBCH read address.
- pbch_gnt  out  1  combinational grant.
- fft_mem_addr  out  ADDR_WIDTH  registered RAM read address.
- fft_mem_rd_en  out  1  registered RAM read enable.
- fft_mem_data_i  in  RX_WORD_LENGTH  signed RAM read data, I.
- fft_mem_data_q  in  RX_WORD_LENGTH  signed RAM read data, Q.
- dmrs_rx_i, dmrs_rx_q  out  RX_WORD_LENGTH each  registered returned sample.
- dmrs_rx_vld  out  1  one-cycle strobe per returned DMRS sample.
- pbch_rx_i, pbch_rx_q  out  RX_WORD_LENGTH each  registered returned sample.
- pbch_rx_vld  out  1  one-cycle strobe per returned PBCH sample.

Behaviour:
- Reset: one clock, one synchronous active-high reset, rst.
  - All registered outputs go to 0, except arb_idle = 1.
  - State goes to IDLE; tag pipeline cleared.
  - Last-grant pointer set to PBCH, so DMRS wins the first tie.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when arb_en = 1.
  - RUN -> DRAIN when arb_en = 0.
  - DRAIN -> IDLE when the tag pipeline is empty (no valid stages).
  - DRAIN -> RUN if arb_en returns to 1 before the pipeline empties; in-flight reads are kept.
- Grants:
  - Issued only in RUN, at most one per cycle.
  - gnt depends combinationally on req, state and the pointer.
  - A grant with req = 0 is illegal and never produced.
  - No grants in IDLE or DRAIN.
- Arbitration (without macro): fixed priority, DMRS over PBCH.
- Issue: a grant in cycle T registers the winner's address into fft_mem_addr and sets fft_mem_rd_en = 1 in T+1.
  - fft_mem_rd_en = 0 in any cycle following a no-grant cycle.
  - fft_mem_addr holds its last value when there is no grant.
- Tag pipeline:
  - Shift register, depth RD_LATENCY+1, of {valid, id}; entry written at grant.
  - RAM data is sampled when the tag reaches the last stage: cycle T+1+RD_LATENCY.
  - Sample is registered into the matching requester's rx_i/rx_q, with rx_vld = 1 in T+2+RD_LATENCY.
  - Grant-to-vld latency is RD_LATENCY+2 (3 at default).
- Return ordering: in-order, no reordering. The non-selected requester's rx_i/q hold their previous value and its vld = 0.
- Throughput: one read per cycle sustained, back-to-back, with interleaved ids allowed.
- Simultaneous events:
  - Both requests with arb_en falling in the same cycle: no grant.
  - rst at any cycle overrides everything; in-flight data is discarded and no vld is produced after reset.
- arb_idle is registered: 1 in IDLE with the pipeline empty, otherwise 0.

Optional Feature:
- Macro: FFT_RD_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a tie, the requester not granted last wins.
  - The pointer updates only on a grant.
  - The pointer resets to PBCH.
- Undefined: fixed DMRS priority; the pointer register is not built.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset then arb_en = 1, dmrs_req = 1, addr = 10'd5, RAM returns I = 12'h123, Q = 12'hF00.
  - Required: dmrs_gnt in the same cycle; fft_mem_rd_en = 1 with addr = 5 one cycle later; dmrs_rx_vld = 1 with I = 12'h123, Q = 12'hF00 three cycles after the grant.
  - Required: pbch_rx_vld stays 0.
- Both requesters held for 6 cycles, addrs 100..105 (DMRS) and 200..205 (PBCH).
  - Fixed build: six DMRS grants, then PBCH grants.
  - FFT_RD_ARB_RR_EN build: alternating grants D, P, D, P, ...; returned ids match the issue order.
- arb_en drops one cycle after 2 grants.
  - Required: state DRAIN, both vlds still delivered, then arb_idle = 1 at grant+4 cycles.
  - Required: no grants issued while arb_en = 0.
- rst asserted while 2 reads are in flight.
  - Required: next cycle all outputs 0 and arb_idle = 1; no vld pulses afterwards.
- RD_LATENCY = 3, a single PBCH read.
  - Required: pbch_rx_vld exactly 5 cycles after pbch_gnt.
- No requests in RUN for 10 cycles.
  - Required: fft_mem_rd_en = 0, gnts 0, arb_idle = 0.

Source files
------------

// File: rtl/fft_mem_rd_arbiter.sv
// Read-port arbiter for the post-FFT RX sample RAM.
// Requester 0 is the DMRS-index generator and requester 1 is the PBCH-index generator.
// Grants are issued one per cycle, and each read carries a tag so the sample returns to its issuer.
// Optional macro FFT_RD_ARB_RR_EN selects round-robin arbitration.
// Without the macro, DMRS has fixed priority.
module fft_mem_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned RX_WORD_LENGTH = 12,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    output logic                      arb_idle,
    input  logic                      dmrs_req,
    input  logic [ADDR_WIDTH-1:0]     dmrs_addr,
    output logic                      dmrs_gnt,
    input  logic                      pbch_req,
    input  logic [ADDR_WIDTH-1:0]     pbch_addr,
    output logic                      pbch_gnt,
    output logic [ADDR_WIDTH-1:0]     fft_mem_addr,
    output logic                      fft_mem_rd_en,
    input  logic [RX_WORD_LENGTH-1:0] fft_mem_data_i,
    input  logic [RX_WORD_LENGTH-1:0] fft_mem_data_q,
    output logic [RX_WORD_LENGTH-1:0] dmrs_rx_i,
    output logic [RX_WORD_LENGTH-1:0] dmrs_rx_q,
    output logic                      dmrs_rx_vld,
    output logic [RX_WORD_LENGTH-1:0] pbch_rx_i,
    output logic [RX_WORD_LENGTH-1:0] pbch_rx_q,
    output logic                      pbch_rx_vld
);

    localparam int unsigned TAG_DEPTH = RD_LATENCY + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [TAG_DEPTH-1:0] tag_vld;
    logic [TAG_DEPTH-1:0] tag_id;     // 0 = DMRS, 1 = PBCH
    logic                 grant_ok;
    logic                 dmrs_win;
    logic                 any_gnt;
    logic                 pipe_empty;

    // Grants are gated by arb_en as well, so a falling arb_en blocks a grant in the same cycle.
    assign grant_ok   = (state == RUN) && arb_en;
    assign pipe_empty = (tag_vld == '0);

`ifdef FFT_RD_ARB_RR_EN
    logic last_pbch;

    // On a tie, the requester not granted last wins.
    assign dmrs_win = dmrs_req && (!pbch_req || last_pbch);

    // The last-grant pointer moves only when a grant is issued.
    // Its reset value favours DMRS on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pbch <= 1'b1;
        end else if (any_gnt) begin
            last_pbch <= pbch_gnt;
        end
    end
`else
    // Fixed priority: DMRS wins whenever it requests.
    assign dmrs_win = dmrs_req;
`endif

    assign dmrs_gnt = grant_ok && dmrs_win;
    assign pbch_gnt = grant_ok && pbch_req && !dmrs_win;
    assign any_gnt  = dmrs_gnt || pbch_gnt;

    // Control FSM: IDLE / RUN / DRAIN, with arb_idle as a registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            arb_idle <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en) begin
                        state    <= RUN;
                        arb_idle <= 1'b0;
                    end else begin
                        arb_idle <= 1'b1;
                    end
                end
                RUN: begin
                    arb_idle <= 1'b0;
                    if (!arb_en) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state    <= IDLE;
                        arb_idle <= 1'b1;
                    end else begin
                        arb_idle <= 1'b0;
                        if (arb_en) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    arb_idle <= 1'b1;
                end
            endcase
        end
    end

    // RAM read issue: register the winner's address; the address holds when there is no grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            fft_mem_rd_en <= 1'b0;
            fft_mem_addr  <= '0;
        end else begin
            fft_mem_rd_en <= any_gnt;
            if (dmrs_gnt) begin
                fft_mem_addr <= dmrs_addr;
            end else if (pbch_gnt) begin
                fft_mem_addr <= pbch_addr;
            end
        end
    end

    // Tag shift register: the tag reaches the last stage in the cycle the RAM data is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[TAG_DEPTH-2:0], any_gnt};
            tag_id  <= {tag_id[TAG_DEPTH-2:0], pbch_gnt};
        end
    end

    // Return path: capture the RAM data into the issuing requester's registers only.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmrs_rx_vld <= 1'b0;
            pbch_rx_vld <= 1'b0;
            dmrs_rx_i   <= '0;
            dmrs_rx_q   <= '0;
            pbch_rx_i   <= '0;
            pbch_rx_q   <= '0;
        end else begin
            dmrs_rx_vld <= tag_vld[RD_LATENCY] && !tag_id[RD_LATENCY];
            pbch_rx_vld <= tag_vld[RD_LATENCY] &&  tag_id[RD_LATENCY];
            if (tag_vld[RD_LATENCY] && !tag_id[RD_LATENCY]) begin
                dmrs_rx_i <= fft_mem_data_i;
                dmrs_rx_q <= fft_mem_data_q;
            end
            if (tag_vld[RD_LATENCY] && tag_id[RD_LATENCY]) begin
                pbch_rx_i <= fft_mem_data_i;
                pbch_rx_q <= fft_mem_data_q;
            end
        end
    end

endmodule

// File: tb/tb_fft_mem_rd_arbiter.sv
// Testbench for fft_mem_rd_arbiter.
// It covers directed scenarios and a randomized run against a cycle-level reference model.
// Also honours FFT_RD_ARB_RR_EN.
module tb_fft_mem_rd_arbiter;

    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 12;
    localparam int          LAT = 1;
`ifdef FFT_RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (default latency) ----------------
    logic          rst = 1'b1, arb_en = 1'b0, arb_idle;
    logic          dmrs_req = 1'b0, pbch_req = 1'b0, dmrs_gnt, pbch_gnt;
    logic [AW-1:0] dmrs_addr = '0, pbch_addr = '0, fft_mem_addr;
    logic          fft_mem_rd_en;
    logic [DW-1:0] fft_mem_data_i, fft_mem_data_q;
    logic [DW-1:0] dmrs_rx_i, dmrs_rx_q, pbch_rx_i, pbch_rx_q;
    logic          dmrs_rx_vld, pbch_rx_vld;

    fft_mem_rd_arbiter u_dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .arb_idle(arb_idle),
        .dmrs_req(dmrs_req), .dmrs_addr(dmrs_addr), .dmrs_gnt(dmrs_gnt),
        .pbch_req(pbch_req), .pbch_addr(pbch_addr), .pbch_gnt(pbch_gnt),
        .fft_mem_addr(fft_mem_addr), .fft_mem_rd_en(fft_mem_rd_en),
        .fft_mem_data_i(fft_mem_data_i), .fft_mem_data_q(fft_mem_data_q),
        .dmrs_rx_i(dmrs_rx_i), .dmrs_rx_q(dmrs_rx_q), .dmrs_rx_vld(dmrs_rx_vld),
        .pbch_rx_i(pbch_rx_i), .pbch_rx_q(pbch_rx_q), .pbch_rx_vld(pbch_rx_vld)
    );

    // RAM model with a one-cycle read latency.
    logic [DW-1:0] mem_i [1024];
    logic [DW-1:0] mem_q [1024];
    logic [AW-1:0] ram_addr_q = '0;
    always @(posedge clk) ram_addr_q <= fft_mem_addr;
    assign fft_mem_data_i = mem_i[ram_addr_q];
    assign fft_mem_data_q = mem_q[ram_addr_q];

    // ---------------- second DUT with RD_LATENCY = 3 ----------------
    logic          rst3 = 1'b1, en3 = 1'b0, idle3;
    logic          dreq3 = 1'b0, preq3 = 1'b0, dgnt3, pgnt3;
    logic [AW-1:0] daddr3 = '0, paddr3 = '0, maddr3;
    logic          rden3;
    logic [DW-1:0] d3_i, d3_q, dri3, drq3, pri3, prq3;
    logic          dvld3, pvld3;
    assign d3_i = 12'h7A5;
    assign d3_q = 12'h05A;

    fft_mem_rd_arbiter #(.RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst3), .arb_en(en3), .arb_idle(idle3),
        .dmrs_req(dreq3), .dmrs_addr(daddr3), .dmrs_gnt(dgnt3),
        .pbch_req(preq3), .pbch_addr(paddr3), .pbch_gnt(pgnt3),
        .fft_mem_addr(maddr3), .fft_mem_rd_en(rden3),
        .fft_mem_data_i(d3_i), .fft_mem_data_q(d3_q),
        .dmrs_rx_i(dri3), .dmrs_rx_q(drq3), .dmrs_rx_vld(dvld3),
        .pbch_rx_i(pri3), .pbch_rx_q(prq3), .pbch_rx_vld(pvld3)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } ret_t;

    ret_t          rq[$];
    int            cyc;
    int            m_mode;
    bit            m_last_p;
    bit            m_rd_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_di, m_dq, m_pi, m_pq;
    int            m_last_gnt;
    bit            e_dg, e_pg, obs_dg, obs_pg;

    task automatic m_reset();
        m_mode     = M_IDLE;
        m_last_p   = 1'b1;
        m_rd_en    = 1'b0;
        m_addr     = '0;
        m_di = '0; m_dq = '0; m_pi = '0; m_pq = '0;
        m_last_gnt = -100;
        rq.delete();
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, compare, then advance the model.
    task automatic step(input bit r, input bit en, input bit dr, input logic [AW-1:0] da,
                        input bit pr, input logic [AW-1:0] pa);
        bit   dv, pv, empty;
        ret_t e;
        dv = 1'b0;
        pv = 1'b0;
        @(posedge clk);
        #1;
        rst = r; arb_en = en; dmrs_req = dr; dmrs_addr = da; pbch_req = pr; pbch_addr = pa;
        @(negedge clk);
        cyc++;
        e_dg = (m_mode == M_RUN) && en && dr && (RR ? (!pr || m_last_p) : 1'b1);
        e_pg = (m_mode == M_RUN) && en && pr && !e_dg;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            if (e.id) begin pv = 1'b1; m_pi = e.i; m_pq = e.q; end
            else      begin dv = 1'b1; m_di = e.i; m_dq = e.q; end
        end
        obs_dg = dmrs_gnt;
        obs_pg = pbch_gnt;
        check("dmrs_gnt", 32'(dmrs_gnt), 32'(e_dg));
        check("pbch_gnt", 32'(pbch_gnt), 32'(e_pg));
        check("rd_en", 32'(fft_mem_rd_en), 32'(m_rd_en));
        check("mem_addr", 32'(fft_mem_addr), 32'(m_addr));
        check("arb_idle", 32'(arb_idle), 32'(m_mode == M_IDLE));
        check("dmrs_vld", 32'(dmrs_rx_vld), 32'(dv));
        check("pbch_vld", 32'(pbch_rx_vld), 32'(pv));
        check("dmrs_i", 32'(dmrs_rx_i), 32'(m_di));
        check("dmrs_q", 32'(dmrs_rx_q), 32'(m_dq));
        check("pbch_i", 32'(pbch_rx_i), 32'(m_pi));
        check("pbch_q", 32'(pbch_rx_q), 32'(m_pq));
        if (r) begin
            m_reset();
        end else begin
            // In-flight tags exist iff a grant happened within the last LAT+1 cycles.
            empty   = (cyc - m_last_gnt) > (LAT + 1);
            m_rd_en = e_dg || e_pg;
            if (e_dg || e_pg) begin
                m_addr     = e_dg ? da : pa;
                rq.push_back('{due: cyc + LAT + 2, id: e_pg, i: mem_i[m_addr], q: mem_q[m_addr]});
                m_last_gnt = cyc;
                m_last_p   = e_pg;
            end
            case (m_mode)
                M_IDLE:  if (en) m_mode = M_RUN;
                M_RUN:   if (!en) m_mode = M_DRAIN;
                default: if (empty) m_mode = M_IDLE; else if (en) m_mode = M_RUN;
            endcase
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int            nd, np, guard, d_seen, first_p, lat;
        bit            r, en, pd, pp;
        logic [AW-1:0] da, pa;

        for (int i = 0; i < 1024; i++) begin
            mem_i[i] = DW'($urandom);
            mem_q[i] = DW'($urandom);
        end
        mem_i[5] = 12'h123;
        mem_q[5] = 12'hF00;

        repeat (2) @(posedge clk);
        m_reset();
        cyc = 0;

        // Single DMRS read of address 5.
        step(0, 1, 0, '0, 0, '0);
        step(0, 1, 1, 10'd5, 0, '0);
        repeat (4) step(0, 1, 0, '0, 0, '0);
        check("dmrs_i_addr5", 32'(dmrs_rx_i), 32'h123);
        check("dmrs_q_addr5", 32'(dmrs_rx_q), 32'hF00);

        // Both requesters held: fixed priority or alternating.
        step(1, 1, 0, '0, 0, '0);
        step(0, 1, 0, '0, 0, '0);
        nd = 0; np = 0; guard = 0; d_seen = 0; first_p = -1;
        while ((nd < 6 || np < 6) && guard < 40) begin
            step(0, 1, nd < 6, AW'(100 + nd), np < 6, AW'(200 + np));
            if (obs_pg && first_p < 0) first_p = d_seen;
            if (obs_dg) d_seen++;
            if (e_dg) nd++;
            if (e_pg) np++;
            guard++;
        end
        check("both_done", 32'(guard < 40), 32'd1);
        check("first_pbch_pos", 32'(first_p), RR ? 32'd1 : 32'd6);
        repeat (4) step(0, 1, 0, '0, 0, '0);

        // Two grants, then arb_en drops while both requesters are held.
        step(0, 1, 1, 10'd300, 0, '0);
        step(0, 1, 1, 10'd301, 0, '0);
        repeat (6) step(0, 0, 1, 10'd302, 1, 10'd400);
        check("drain_idle", 32'(arb_idle), 32'd1);

        // Reset while two reads are in flight.
        step(0, 1, 1, 10'd302, 1, 10'd400);
        step(0, 1, 1, 10'd302, 1, 10'd400);
        step(0, 1, 0, '0, 1, 10'd400);
        step(1, 1, 0, '0, 0, '0);
        repeat (6) step(0, 0, 0, '0, 0, '0);
        check("post_rst_idle", 32'(arb_idle), 32'd1);

        // RUN with no requests.
        step(0, 1, 0, '0, 0, '0);
        repeat (10) step(0, 1, 0, '0, 0, '0);
        check("run_noreq_idle", 32'(arb_idle), 32'd0);
        check("run_noreq_rden", 32'(fft_mem_rd_en), 32'd0);

        // Randomized traffic honouring the hold-until-granted rule.
        en = 1'b1; pd = 1'b0; pp = 1'b0; da = '0; pa = '0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            if (en) en = ($urandom_range(0, 11) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            if (!pd && $urandom_range(0, 2) != 0) begin pd = 1'b1; da = AW'($urandom); end
            if (!pp && $urandom_range(0, 2) != 0) begin pp = 1'b1; pa = AW'($urandom); end
            step(r, en, pd, da, pp, pa);
            if (e_dg || r) pd = 1'b0;
            if (e_pg || r) pp = 1'b0;
        end

        // RD_LATENCY = 3: single PBCH read, grant-to-valid latency.
        @(posedge clk); #1 rst3 = 1'b0; en3 = 1'b1;
        @(posedge clk); #1 preq3 = 1'b1; paddr3 = 10'd7;
        @(negedge clk);
        check("lat3_gnt", 32'(pgnt3), 32'd1);
        @(posedge clk); #1 preq3 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pvld3 && lat == 0) lat = k;
        end
        check("lat3_latency", 32'(lat), 32'd5);
        check("lat3_data_i", 32'(pri3), 32'h7A5);
        check("lat3_dmrs_vld", 32'(dvld3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
